cam_wr_ctrl: RTL and testbench
==============================

# cam_wr_ctrl

Camera-side SDRAM write scheduler in the 133 MHz domain. Drains the camera pixel FIFO into SDRAM in fixed-length bursts, addressed into the bank currently owned by the camera (`cam_bank` from `bank_switch`). Produces the `cam_rise` frame-complete level that `bank_switch` edge-detects to rotate the triple buffer.

## Interface
Parameters:
- `ADDR_W`, 22: SDRAM word address width; top 2 bits are the bank.
- `BURST_LEN`, 256: words per write burst (full page).
- `FRAME_WORDS`, 307200: words per frame. Must be a multiple of `BURST_LEN` and less than 2^(ADDR_W-2).
- `FIFO_CNT_W`, 10: width of the FIFO fill count.

Ports:
- `clk`  in  1  133 MHz system clock.
- `rst_133`  in  1  asynchronous, active-low reset.
- `cam_vsync`  in  1  camera vsync, asynchronous to `clk`; rising edge marks frame start.
- `cam_bank`  in  2  SDRAM bank to write, from `bank_switch`.
- `fifo_usedw`  in  FIFO_CNT_W  words available in the camera FIFO.
- `fifo_clr`  out  1  one-cycle FIFO clear pulse.
- `wr_req`  out  1  burst write request to the SDRAM controller.
- `wr_ack`  in  1  controller accepted the request.
- `wr_addr`  out  ADDR_W  burst start address `{bank_lat, word_addr}`.
- `wdata_req`  in  1  controller wants one data word this cycle.
- `fifo_rd`  out  1  FIFO read strobe.
- `cam_rise`  out  1  high from frame completion until the next frame start.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `err_cnt`  out  8  aborted-frame counter. Present only with `CAM_WR_ERRCNT_EN`.

## Operation
- `cam_vsync` passes through a 2-flop synchronizer. `vs_rise` is a one-cycle pulse on the synchronized rising edge.
- States: IDLE, WAIT_DATA, REQ, BURST.
- IDLE: on `vs_rise`:
  - latch `cam_bank` into `bank_lat`;
  - clear `word_addr` and `burst_cnt`;
  - pulse `fifo_clr`;
  - drop `cam_rise`;
  - go to WAIT_DATA.
- WAIT_DATA: when `fifo_usedw >= BURST_LEN`, go to REQ.
- REQ: hold `wr_req` high with `wr_addr` stable until `wr_ack` is sampled high, then go to BURST.
- BURST:
  - `fifo_rd = wdata_req`, combinational, gated by state == BURST;
  - count `wdata_req` cycles;
  - on the `BURST_LEN`-th word, `word_addr += BURST_LEN`;
  - if the new `word_addr == FRAME_WORDS`, set `cam_rise` and go to IDLE; otherwise go to WAIT_DATA.
- Early frame: `vs_rise` in WAIT_DATA or REQ:
  - pulse `frame_err`;
  - perform the IDLE frame-start actions;
  - stay in WAIT_DATA;
  - `cam_rise` stays low.
- `vs_rise` in BURST: the burst completes first. The pending start is held in a sticky flag and serviced as the early-frame abort on burst exit. A burst is never cut short.
- `bank_lat` is constant for the whole frame. `cam_bank` changes mid-frame are ignored.
- `wdata_req` outside BURST: ignored, `fifo_rd` stays 0.

## Timing
- Reset values:
  - outputs: `wr_req`, `fifo_rd`, `fifo_clr`, `cam_rise`, `frame_err`, `wr_addr` and `err_cnt` are all 0;
  - internal: state IDLE, sticky flag clear.
- Sync latency: `vs_rise` fires 2–3 `clk` cycles after the `cam_vsync` edge.
- Frame-start actions happen in the same cycle as `vs_rise`:
  - `fifo_clr` and `frame_err` are registered, high the cycle after;
  - `cam_rise` falls the cycle after.
- `wr_req` rises the cycle after entering REQ and falls the cycle after `wr_ack` is sampled.
- `cam_rise` rises the cycle after the last `wdata_req` of the frame.
- Reset mid-burst: all outputs return to reset values immediately; the partial frame is discarded.

## Configuration
- `CAM_WR_ERRCNT_EN` defined:
  - `err_cnt` port exists;
  - it increments on each `frame_err` and saturates at 255;
  - it is cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `cam_wr_pkg`:
  - state enum `cam_wr_state_t`;
  - `BANK_W = 2`;
  - reset-default constants.
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge pulse, reused for `cam_vsync`.

## Test plan
- Reset with `cam_bank=2'b01`, then vsync edge: `fifo_clr` pulses once, `bank_lat=01`, `cam_rise=0`, no `wr_req` while `fifo_usedw<256`.
- `fifo_usedw=256`, controller acks after 3 cycles and gives 256 `wdata_req`: `wr_addr=22'h100000`, `wr_req` high exactly until the ack, 256 `fifo_rd` pulses, next request addresses `22'h100100`.
- Full frame with `FRAME_WORDS=1024`, `BURST_LEN=256`: 4 bursts at word offsets 0/256/512/768, then `cam_rise=1` held until the next vsync edge.
- `cam_bank` toggles 01→10 mid-frame: all remaining bursts still use bank 01; the next frame uses 10.
- vsync during WAIT_DATA after 2 bursts: `frame_err` pulses, address restarts at 0, `cam_rise` never asserts. With the macro, `err_cnt` goes 0→1; after 300 aborts it stays at 255.
- vsync mid-BURST: the burst finishes all 256 words, then the abort and restart occur the cycle after the last `wdata_req`.

Source files
------------

// File: rtl/cam_wr_pkg.sv
// Shared types and reset constants for the camera-side SDRAM write scheduler.
package cam_wr_pkg;

  localparam int unsigned BANK_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_REQ       = 2'd2,
    ST_BURST     = 2'd3
  } cam_wr_state_t;

  // Registered single-bit controls that leave the block.
  typedef struct packed {
    logic wr_req;
    logic fifo_clr;
    logic frame_err;
    logic cam_rise;
  } cam_wr_flags_t;

  localparam cam_wr_state_t RST_STATE = ST_IDLE;
  localparam cam_wr_flags_t RST_FLAGS = '0;
  localparam logic [7:0]    RST_ERRCNT = 8'd0;

endpackage

// File: rtl/cam_wr_ctrl_if.sv
// SDRAM write-request and camera FIFO handshake bundle between the scheduler and its neighbours.
interface cam_wr_ctrl_if #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned FIFO_CNT_W = 10
);
  logic                  wr_req;
  logic                  wr_ack;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  wdata_req;
  logic                  fifo_rd;
  logic                  fifo_clr;
  logic [FIFO_CNT_W-1:0] fifo_usedw;

  modport master (
    output wr_req, wr_addr, fifo_rd, fifo_clr,
    input  wr_ack, wdata_req, fifo_usedw
  );

  modport slave (
    input  wr_req, wr_addr, fifo_rd, fifo_clr,
    output wr_ack, wdata_req, fifo_usedw
  );
endinterface

// File: rtl/cam_wr_ctrl_sync_edge.sv
// Two-flop synchronizer with a one-cycle pulse on the synchronized rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst_133,
  input  logic d,
  output logic rise_c
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;
endmodule

// File: rtl/cam_wr_ctrl.sv
// Camera FIFO to SDRAM burst write scheduler; raises cam_rise when a full frame has landed.
// Optional aborted-frame counter port err_cnt is built when CAM_WR_ERRCNT_EN is defined.
module cam_wr_ctrl
  import cam_wr_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned FIFO_CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_133,
  input  logic              cam_vsync,
  input  logic [BANK_W-1:0] cam_bank,
  cam_wr_ctrl_if.master     bus,
  output logic              cam_rise,
`ifdef CAM_WR_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              frame_err
);

  localparam int unsigned WA_W = ADDR_W - BANK_W;
  localparam int unsigned BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  cam_wr_state_t     state_q, state_d;
  cam_wr_flags_t     flags_q, flags_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [WA_W-1:0]   word_q, word_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q;

  logic            vs_rise;
  logic            last_word;
  logic [WA_W-1:0] word_inc;
  logic            frame_done;
  logic            abort;
  logic            start;

  sync_edge u_vs_sync (
    .clk     (clk),
    .rst_133 (rst_133),
    .d       (cam_vsync),
    .rise_c  (vs_rise)
  );

  assign last_word  = (state_q == ST_BURST) && bus.wdata_req &&
                      (bcnt_q == BC_W'(BURST_LEN - 1));
  assign word_inc   = word_q + WA_W'(BURST_LEN);
  assign frame_done = (word_inc == WA_W'(FRAME_WORDS));
  // A frame start outside IDLE aborts; inside a burst it waits for the last word.
  assign abort      = (vs_rise && ((state_q == ST_WAIT_DATA) || (state_q == ST_REQ))) ||
                      (last_word && (pend_q || vs_rise));
  assign start      = (vs_rise && (state_q == ST_IDLE)) || abort;

  // State register
  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (vs_rise) state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (vs_rise)                                   state_d = ST_WAIT_DATA;
        else if (32'(bus.fifo_usedw) >= BURST_LEN)     state_d = ST_REQ;
      end
      ST_REQ: begin
        if (vs_rise)                                   state_d = ST_WAIT_DATA;
        else if (flags_q.wr_req && bus.wr_ack)         state_d = ST_BURST;
      end
      ST_BURST: begin
        if (last_word) begin
          if (pend_q || vs_rise)                       state_d = ST_WAIT_DATA;
          else if (frame_done)                         state_d = ST_IDLE;
          else                                         state_d = ST_WAIT_DATA;
        end
      end
      default:                                         state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    flags_d           = flags_q;
    flags_d.fifo_clr  = 1'b0;
    flags_d.frame_err = 1'b0;
    flags_d.wr_req    = (state_q == ST_REQ) && !vs_rise && !(flags_q.wr_req && bus.wr_ack);
    bank_d            = bank_q;
    word_d            = word_q;
    bcnt_d            = bcnt_q;
    pend_d            = pend_q;

    if (state_q == ST_BURST) begin
      pend_d = pend_q | vs_rise;
      if (bus.wdata_req) bcnt_d = bcnt_q + BC_W'(1);
      if (last_word) begin
        bcnt_d = '0;
        word_d = word_inc;
        if (frame_done && !(pend_q || vs_rise)) flags_d.cam_rise = 1'b1;
      end
    end

    if (start) begin
      bank_d            = cam_bank;
      word_d            = '0;
      bcnt_d            = '0;
      pend_d            = 1'b0;
      flags_d.fifo_clr  = 1'b1;
      flags_d.cam_rise  = 1'b0;
      flags_d.frame_err = abort;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      flags_q <= RST_FLAGS;
      bank_q  <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      flags_q <= flags_d;
      bank_q  <= bank_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= pend_d;
      addr_q  <= {bank_d, word_d};
    end
  end

`ifdef CAM_WR_ERRCNT_EN
  // Saturating count of aborted frames
  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133)                      err_cnt <= RST_ERRCNT;
    else if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

  assign bus.wr_req   = flags_q.wr_req;
  assign bus.fifo_clr = flags_q.fifo_clr;
  assign bus.wr_addr  = addr_q;
  assign bus.fifo_rd  = (state_q == ST_BURST) && bus.wdata_req;
  assign cam_rise     = flags_q.cam_rise;
  assign frame_err    = flags_q.frame_err;

endmodule

// File: tb/tb_cam_wr_ctrl.sv
// Directed bench for cam_wr_ctrl with a 1024-word frame of four 256-word bursts.
module tb_cam_wr_ctrl;
  localparam int unsigned ADDR_W      = 22;
  localparam int unsigned FIFO_CNT_W  = 10;
  localparam int unsigned BURST_LEN   = 256;
  localparam int unsigned FRAME_WORDS = 1024;

  typedef struct {
    logic        new_frame;
    logic [1:0]  bank;
    logic [21:0] exp_addr;
    logic        exp_rise;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_133 = 1'b0;
  logic       cam_vsync = 1'b0;
  logic [1:0] cam_bank = 2'b01;
  logic       cam_rise;
  logic       frame_err;
`ifdef CAM_WR_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  vec_t vecs [6];

  cam_wr_ctrl_if #(.ADDR_W(ADDR_W), .FIFO_CNT_W(FIFO_CNT_W)) bus ();

  cam_wr_ctrl #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .FIFO_CNT_W  (FIFO_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_133   (rst_133),
    .cam_vsync (cam_vsync),
    .cam_bank  (cam_bank),
    .bus       (bus),
    .cam_rise  (cam_rise),
`ifdef CAM_WR_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vsync(input logic exp_err);
    int   clr_n, err_n;
    logic first;
    clr_n = 0; err_n = 0; first = 1'b1;
    cam_vsync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.fifo_clr) begin
        clr_n++;
        if (first) begin
          first = 1'b0;
          chk("cam_rise_at_start", 32'(cam_rise), 32'd0);
        end
      end
      if (frame_err) err_n++;
    end
    chk("fifo_clr_pulses", 32'(clr_n), 32'd1);
    chk("frame_err_pulses", 32'(err_n), exp_err ? 32'd1 : 32'd0);
    cam_vsync = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    bus.fifo_usedw = 10'd256;
    while (!bus.wr_req && n < 40) begin
      step();
      n++;
    end
    chk("wr_req_timeout", 32'(bus.wr_req), 32'd1);
    bus.fifo_usedw = 10'd0;
  endtask

  task automatic do_burst(input logic [21:0] exp_addr, input logic exp_rise);
    int rd_n;
    wait_req();
    chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
    repeat (2) begin
      step();
      chk("wr_req_hold", 32'(bus.wr_req), 32'd1);
    end
    bus.wr_ack = 1'b1;
    step();
    bus.wr_ack = 1'b0;
    chk("wr_req_drop", 32'(bus.wr_req), 32'd0);
    chk("wr_addr_stable", 32'(bus.wr_addr), 32'(exp_addr));
    rd_n = 0;
    bus.wdata_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (bus.fifo_rd) rd_n++;
      @(posedge clk);
      #1;
    end
    bus.wdata_req = 1'b0;
    chk("fifo_rd_count", 32'(rd_n), 32'd256);
    chk("cam_rise_after_burst", 32'(cam_rise), 32'(exp_rise));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic last_rise;
    logic hi, rd;
    int   rd_n, early;

    vecs[0] = '{1'b1, 2'b01, 22'h100000, 1'b0};
    vecs[1] = '{1'b0, 2'b01, 22'h100100, 1'b0};
    vecs[2] = '{1'b0, 2'b10, 22'h100200, 1'b0};
    vecs[3] = '{1'b0, 2'b10, 22'h100300, 1'b1};
    vecs[4] = '{1'b1, 2'b10, 22'h200000, 1'b0};
    vecs[5] = '{1'b0, 2'b10, 22'h200100, 1'b0};

    bus.wr_ack = 1'b0;
    bus.wdata_req = 1'b0;
    bus.fifo_usedw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    chk("rst_fifo_clr", 32'(bus.fifo_clr), 32'd0);
    chk("rst_cam_rise", 32'(cam_rise), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
`ifdef CAM_WR_ERRCNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_133 = 1'b1;
    step();

    last_rise = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cam_bank = vecs[i].bank;
      if (vecs[i].new_frame) begin
        repeat (5) step();
        chk("cam_rise_held", 32'(cam_rise), 32'(last_rise));
        do_vsync(1'b0);
        bus.fifo_usedw = 10'd255;
        bus.wdata_req = 1'b1;
        hi = 1'b0; rd = 1'b0;
        repeat (6) begin
          step();
          if (bus.wr_req) hi = 1'b1;
          if (bus.fifo_rd) rd = 1'b1;
        end
        bus.wdata_req = 1'b0;
        chk("no_req_below_burst", 32'(hi), 32'd0);
        chk("no_rd_outside_burst", 32'(rd), 32'd0);
      end
      do_burst(vecs[i].exp_addr, vecs[i].exp_rise);
      last_rise = vecs[i].exp_rise;
    end

    // Early frame while waiting for data after two bursts
    do_vsync(1'b1);
`ifdef CAM_WR_ERRCNT_EN
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
`endif
    do_burst(22'h200000, 1'b0);

    // Frame start arriving mid-burst is deferred to the last word
    wait_req();
    chk("wr_addr_midburst", 32'(bus.wr_addr), 32'h200100);
    bus.wr_ack = 1'b1;
    step();
    bus.wr_ack = 1'b0;
    cam_vsync = 1'b1;
    rd_n = 0; early = 0;
    bus.wdata_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (bus.fifo_rd) rd_n++;
      if (bus.fifo_clr || frame_err) early++;
      @(posedge clk);
      #1;
    end
    bus.wdata_req = 1'b0;
    chk("midburst_rd_count", 32'(rd_n), 32'd256);
    chk("midburst_no_early_abort", 32'(early), 32'd0);
    chk("midburst_fifo_clr", 32'(bus.fifo_clr), 32'd1);
    chk("midburst_frame_err", 32'(frame_err), 32'd1);
    chk("midburst_cam_rise", 32'(cam_rise), 32'd0);
    cam_vsync = 1'b0;
    step();
    chk("midburst_clr_one_cycle", 32'(bus.fifo_clr), 32'd0);
    repeat (3) step();
`ifdef CAM_WR_ERRCNT_EN
    chk("err_cnt_two", 32'(err_cnt), 32'd2);
`endif
    do_burst(22'h200000, 1'b0);

    // Reset in the middle of a burst
    wait_req();
    bus.wr_ack = 1'b1;
    step();
    bus.wr_ack = 1'b0;
    bus.wdata_req = 1'b1;
    repeat (10) step();
    #2 rst_133 = 1'b0;
    #1;
    chk("rstmid_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rstmid_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    chk("rstmid_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rstmid_cam_rise", 32'(cam_rise), 32'd0);
    bus.wdata_req = 1'b0;
    #2 rst_133 = 1'b1;
    step();

`ifdef CAM_WR_ERRCNT_EN
    chk("err_cnt_after_rst", 32'(err_cnt), 32'd0);
    do_vsync(1'b0);
    for (int k = 0; k < 300; k++) begin
      cam_vsync = 1'b1;
      repeat (4) step();
      cam_vsync = 1'b0;
      repeat (3) step();
    end
    chk("err_cnt_saturate", 32'(err_cnt), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
